// File: rtl/fpu_req_arbiter.sv
// Round-robin front end sharing one FPU between NumReq requesters, with credit-bounded issue and tag-routed responses.
// Optional build macro FPU_ARB_FIXED_PRIO_EN gives requester 0 absolute priority over the round-robin group.
module fpu_req_arbiter #(
  parameter int NumReq         = 4,
  parameter int Width          = 32,
  parameter int MaxOutstanding = 4,
  parameter int TagW           = $clog2(NumReq),
  localparam int CredW         = $clog2(MaxOutstanding + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][2:0][Width-1:0]  req_operands_i,
  input  logic [NumReq-1:0][3:0]             req_op_i,
  input  logic [NumReq-1:0]                  req_op_mod_i,
  input  logic [NumReq-1:0][2:0]             req_rnd_mode_i,
  output logic [NumReq-1:0]                  resp_valid_o,
  input  logic [NumReq-1:0]                  resp_ready_i,
  output logic [Width-1:0]                   resp_result_o,
  output logic [4:0]                         resp_status_o,
  output logic [2:0][Width-1:0]              fpu_operands_o,
  output logic [3:0]                         fpu_op_o,
  output logic                               fpu_op_mod_o,
  output logic [2:0]                         fpu_rnd_mode_o,
  output logic [TagW-1:0]                    fpu_tag_o,
  output logic                               fpu_in_valid_o,
  input  logic                               fpu_in_ready_i,
  input  logic [Width-1:0]                   fpu_result_i,
  input  logic [4:0]                         fpu_status_i,
  input  logic [TagW-1:0]                    fpu_tag_i,
  input  logic                               fpu_out_valid_i,
  output logic                               fpu_out_ready_o,
  output logic                               fpu_flush_o,
  output logic [CredW-1:0]                   credits_o
);

  typedef enum logic {S_EMPTY, S_FULL} slot_state_e;

  slot_state_e          state_reg, state_next;
  logic [TagW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [CredW-1:0]     credits_reg, credits_next;
  logic [2:0][Width-1:0] operands_reg;
  logic [3:0]           op_reg;
  logic                 op_mod_reg;
  logic [2:0]           rnd_mode_reg;
  logic [TagW-1:0]      tag_reg;

  logic                 issue, ret, credit_ok, can_capture, capture;
  logic                 any_req, inc, dec;
  logic [TagW-1:0]      winner, idx;
  logic [NumReq-1:0]    tag_hit;

  assign issue = (state_reg == S_FULL) && fpu_in_ready_i;
  assign ret   = fpu_out_valid_i && fpu_out_ready_o;

  // The last credit may only refill the slot if it is not being spent by this cycle's issue.
  assign credit_ok   = (credits_reg > CredW'(1)) ||
                       ((credits_reg == CredW'(1)) && (!issue || ret));
  assign can_capture = !flush_i && credit_ok && ((state_reg == S_EMPTY) || issue);
  assign capture     = can_capture && any_req;

`ifdef FPU_ARB_FIXED_PRIO_EN
  int base_idx;

  // Requester 0 bypasses the rotation; rr_ptr only ever walks 1..NumReq-1.
  always_comb begin
    any_req     = 1'b0;
    winner      = '0;
    idx         = '0;
    base_idx    = (rr_ptr_reg == '0) ? 0 : int'(rr_ptr_reg) - 1;
    for (int i = 0; i < NumReq - 1; i++) begin
      idx = TagW'(1 + (base_idx + i) % (NumReq - 1));
      if (!any_req && req_valid_i[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
    if (req_valid_i[0]) begin
      any_req = 1'b1;
      winner  = '0;
    end
    rr_ptr_next = (winner == TagW'(NumReq - 1)) ? TagW'(1) : winner + TagW'(1);
  end
`else
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = TagW'((int'(rr_ptr_reg) + i) % NumReq);
      if (!any_req && req_valid_i[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
    rr_ptr_next = (winner == TagW'(NumReq - 1)) ? '0 : winner + TagW'(1);
  end
`endif

  always_comb begin
    state_next     = state_reg;
    fpu_in_valid_o = 1'b0;
    case (state_reg)
      S_EMPTY: if (capture) state_next = S_FULL;
      S_FULL: begin
        fpu_in_valid_o = 1'b1;
        if (!capture && fpu_in_ready_i) state_next = S_EMPTY;
      end
      default: state_next = S_EMPTY;
    endcase
    if (flush_i) state_next = S_EMPTY;
  end

  // A spurious return at full credit is ignored unless an issue balances it.
  always_comb begin
    inc          = ret && ((credits_reg != CredW'(MaxOutstanding)) || issue);
    dec          = issue && (credits_reg != '0);
    credits_next = credits_reg;
    if (flush_i)          credits_next = CredW'(MaxOutstanding);
    else if (inc && !dec) credits_next = credits_reg + CredW'(1);
    else if (dec && !inc) credits_next = credits_reg - CredW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= S_EMPTY;
      rr_ptr_reg   <= '0;
      credits_reg  <= CredW'(MaxOutstanding);
      operands_reg <= '0;
      op_reg       <= '0;
      op_mod_reg   <= 1'b0;
      rnd_mode_reg <= '0;
      tag_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      credits_reg <= credits_next;
      if (capture) begin
        rr_ptr_reg   <= rr_ptr_next;
        operands_reg <= req_operands_i[winner];
        op_reg       <= req_op_i[winner];
        op_mod_reg   <= req_op_mod_i[winner];
        rnd_mode_reg <= req_rnd_mode_i[winner];
        tag_reg      <= winner;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_route
      assign req_ready_o[gi]  = capture && (winner == TagW'(gi));
      assign tag_hit[gi]      = (fpu_tag_i == TagW'(gi));
      assign resp_valid_o[gi] = fpu_out_valid_i && tag_hit[gi];
    end
  endgenerate

  assign fpu_out_ready_o = |(tag_hit & resp_ready_i);
  assign resp_result_o   = fpu_result_i;
  assign resp_status_o   = fpu_status_i;
  assign fpu_operands_o  = operands_reg;
  assign fpu_op_o        = op_reg;
  assign fpu_op_mod_o    = op_mod_reg;
  assign fpu_rnd_mode_o  = rnd_mode_reg;
  assign fpu_tag_o       = tag_reg;
  assign fpu_flush_o     = flush_i;
  assign credits_o       = credits_reg;

endmodule
